// File: rtl/risc16_mem_pkg.sv
// risc16_mem_pkg
//   Shared definitions for the single-port 256x16 data RAM and its initiators:
//   RAM geometry, the block-mover FSM state encoding and the legal range of
//   the RAM read latency.
package risc16_mem_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 16;

    // RAM read latency, edge latching the address -> ram_dout valid
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Block mover FSM encoding (kept numerically stable for legacy decode)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WAIT = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_DONE = 3'd4;
    localparam state_t ST_FILL = 3'd5;

endpackage

// File: rtl/ram_block_mover.sv
// ram_block_mover
//   Copies len 16-bit words from src_addr to dst_addr inside the shared
//   256x16 single-port RAM, one word per RD/WAIT/WR round, ascending
//   addresses with 8-bit wrap, then pulses done.
//
// Parameters
//   RD_LAT     RAM read latency in cycles (1..3)
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   src_addr, dst_addr  first source / destination word address
//   len                 word count 0..256
//   busy                high from the cycle after accepted start through DONE
//   done                one-cycle completion pulse
//   ram_we, ram_addr, ram_din   RAM write enable / address / write data
//   ram_dout            RAM read data
//   fill, fill_data     (RAM_MOVER_FILL_MODE_EN only) write fill_data to len
//                       consecutive destination words, one per cycle
//
// Build option
//   RAM_MOVER_FILL_MODE_EN   adds the fill ports and the FILL state.
module ram_block_mover
    import risc16_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [RAM_AW-1:0] src_addr,
    input  logic [RAM_AW-1:0] dst_addr,
    input  logic [RAM_AW:0]   len,
`ifdef RAM_MOVER_FILL_MODE_EN
    input  logic              fill,
    input  logic [RAM_DW-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("ram_block_mover: RD_LAT out of range");
    end

    localparam int LW = $clog2(RD_LAT_MAX + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

    state_t            state_q;
    logic [RAM_AW-1:0] src_q;
    logic [RAM_AW-1:0] dst_q;
    logic [RAM_AW:0]   cnt_q;   // one bit wider so len=256 fits
    logic [LW-1:0]     lat_q;
    logic [RAM_DW-1:0] data_q;

    // data_q is a register and only changes on entry to WR/FILL, so the
    // write-data port is driven straight from it.
    assign ram_din = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            lat_q    <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
        end else begin
            // Outputs are loaded on the edge entering a state so that they
            // are valid for the whole cycle spent in it.
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        cnt_q <= len;
                        busy  <= 1'b1;
`ifdef RAM_MOVER_FILL_MODE_EN
                        if (fill && len != '0) begin
                            state_q  <= ST_FILL;
                            data_q   <= fill_data;
                            ram_addr <= dst_addr;
                            ram_we   <= 1'b1;
                        end else
`endif
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q  <= ST_RD;
                            ram_addr <= src_addr;
                        end
                    end
                end
                ST_RD: begin
                    state_q <= ST_WAIT;
                    lat_q   <= '0;
                end
                ST_WAIT: begin
                    // ram_addr stays on src_q so a pipelined RAM sees a
                    // stable address for the whole latency window.
                    if (lat_q == LAT_LAST) begin
                        state_q  <= ST_WR;
                        data_q   <= ram_dout;
                        ram_addr <= dst_q;
                        ram_we   <= 1'b1;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                ST_WR: begin
                    ram_we <= 1'b0;
                    src_q  <= src_q + 8'd1;
                    dst_q  <= dst_q + 8'd1;
                    cnt_q  <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_q <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        state_q  <= ST_RD;
                        ram_addr <= src_q + 8'd1;
                    end
                end
`ifdef RAM_MOVER_FILL_MODE_EN
                ST_FILL: begin
                    dst_q <= dst_q + 8'd1;
                    cnt_q <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_q <= ST_DONE;
                        ram_we  <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        ram_addr <= dst_q + 8'd1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_block_mover.md
# ram_block_mover

Initiator-side engine for the single-port 256x16 synchronous data RAM. It drives the RAM write enable, address and write-data port and consumes its read-data port. On a start pulse it copies a block of `len` 16-bit words from a source address to a destination address in the same RAM, then pulses `done`. It sits between the processor control unit, which issues the start pulse and arguments, and the RAM port; the RAM port is muxed to the mover while `busy` is high.

## Interface
- `RD_LAT`, 1: RAM read latency in cycles, from the edge that latches the address to `ram_dout` being valid; legal values 1..3.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_addr`  in  8  first source word address; captured on start.
- `dst_addr`  in  8  first destination word address; captured on start.
- `len`  in  9  word count, 0..256; captured on start.
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- `done`  out  1  one-cycle completion pulse.
- `ram_we`  out  1  RAM write enable (maps to wea).
- `ram_addr`  out  8  RAM address.
- `ram_din`  out  16  RAM write data.
- `ram_dout`  in  16  RAM read data.
- `fill`, `fill_data` (in 1 / in 16): present only under FILL_MODE_EN.

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE: when `start`=1, capture the arguments into `src_q`, `dst_q` and `cnt_q`.
  - `len`=0: go to DONE.
  - Otherwise: go to RD.
- RD (1 cycle): `ram_addr`=`src_q`, `ram_we`=0. Go to WAIT.
- WAIT (RD_LAT cycles, counted by `lat_q`): on the last WAIT edge, capture `ram_dout` into `data_q`. Go to WR.
- WR (1 cycle): `ram_addr`=`dst_q`, `ram_din`=`data_q`, `ram_we`=1.
  - Then increment `src_q` and `dst_q` modulo 256 and decrement `cnt_q`.
  - If the count reaches 0, go to DONE; else go to RD.
- DONE (1 cycle): `done`=1, `busy`=1, `ram_we`=0. Go to IDLE.
- Address arithmetic is 8-bit and wraps: 0xFF+1 = 0x00. `cnt_q` is 9 bits wide so that `len`=256 is representable.
- Overlapping regions are copied in ascending order only. With dst > src and overlap, source words are replicated. This behaviour is defined, not an error.
- `start` is ignored in every non-IDLE state; the arguments are not re-sampled.
- All outputs are registered. `ram_we` is never high outside WR (fill mode: outside FILL).

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `ram_we`=0, `ram_addr`=0x00, `ram_din`=0x0000. All internal counters and registers are 0.
- Reset is asserted asynchronously. Mid-transfer it forces `ram_we` low immediately and aborts; the partially written block stays as written.
- Let cycle 0 be the cycle in which `start` is sampled.
  - Copy: word i is in RD at cycle 1 + i·(RD_LAT+2), and `done` is asserted at cycle 1 + len·(RD_LAT+2).
  - `len`=0: `done` at cycle 1, with no RAM access.
- A new `start` is accepted no earlier than the cycle after DONE.

## Configuration
- `RAM_MOVER_FILL_MODE_EN` defined:
  - Adds the `fill` and `fill_data` ports and a FILL state.
  - With `start`=1 and `fill`=1, the block writes `fill_data` to len consecutive `dst` addresses, one word per cycle, with `ram_we`=1 throughout. RD and WAIT are skipped and `src_addr` is ignored.
  - `done` is asserted at cycle len+1.
- Undefined: no FILL state and no fill ports; copy only.

## Structure
- Shared package `risc16_mem_pkg` holds:
  - the state enum encoding (IDLE=0, RD=1, WAIT=2, WR=3, DONE=4, FILL=5);
  - `RAM_AW`=8, `RAM_DW`=16;
  - the RD_LAT legal range.
- The block is a single module with no sub-module.
- The bench instantiates it alongside a behavioural 256x16 RAM model with RD_LAT=1.

## Test plan
- Copy: preload mem[0x10..0x12] = 0xAAAA, 0xBBBB, 0xCCCC. Issue start with src=0x10, dst=0x20, len=3. Required: mem[0x20..0x22] match, `done` at cycle 10, `busy` high for cycles 1..10.
- Wrap: src=0xFE, dst=0x7E, len=4. Required: reads 0xFE, 0xFF, 0x00, 0x01 copied to 0x7E..0x81.
- `len`=0: `done` at cycle 1, `ram_we` never asserted, memory unchanged.
- `start` pulsed while busy: ignored; the first transfer completes unchanged and there is exactly one `done`.
- Assert `reset` during WR of word 1 of a len=3 copy. Required: `ram_we` drops asynchronously, all outputs return to their reset values, and word 0 remains written.
- With `RAM_MOVER_FILL_MODE_EN`: fill with dst=0x40, len=5, `fill_data`=0x1234. Required: mem[0x40..0x44]=0x1234 and `done` at cycle 6.
